// File: rtl/nibble_loader_pkg.sv
// Shared types and sizing helpers for the nibble-serial register loader.
package nibble_loader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int NIB_W = 4;

  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int calc_nibs(input int width);
    return width / NIB_W;
  endfunction

  function automatic int calc_nw(input int width);
    return clog2_min1(calc_nibs(width));
  endfunction

endpackage

// File: rtl/nibble_reg_loader_if.sv
// Nibble stream, channel control and register-bank outputs of the loader.
interface nibble_reg_loader_if
  import nibble_loader_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 32
);
  localparam int CW = clog2_min1(CHANNELS);

  logic [NIB_W-1:0]          din;
  logic                      din_valid;
  logic                      start;
  logic                      clr;
  logic [CW-1:0]             ch_sel;
  logic [CHANNELS*WIDTH-1:0] regs_out;
  logic [CHANNELS-1:0]       loaded;
  logic                      busy;
  logic                      commit;
  logic                      err;

  modport master (
    output din, din_valid, start, clr, ch_sel,
    input  regs_out, loaded, busy, commit, err
  );

  modport slave (
    input  din, din_valid, start, clr, ch_sel,
    output regs_out, loaded, busy, commit, err
  );
endinterface

// File: rtl/nibble_shift_reg.sv
// Shared frame shift register with nibble counter; flags the final nibble of a word.
module nibble_shift_reg
  import nibble_loader_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic             shift_en,
  input  logic [NIB_W-1:0] din,
  output logic [WIDTH-1:0] shreg,
  output logic             last
);
  localparam int NIBS = calc_nibs(WIDTH);
  localparam int NW   = calc_nw(WIDTH);

  logic [NW-1:0] cnt;

  assign last = (cnt == NW'(NIBS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (shift_en) begin
      shreg <= {shreg[WIDTH-NIB_W-1:0], din};
      // Wrap explicitly so non-power-of-two nibble counts stay in range
      cnt   <= last ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/nibble_reg_loader.sv
// Multi-channel nibble-serial loader: frames shift into one register, then commit
// atomically into the selected channel register.
module nibble_reg_loader
  import nibble_loader_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 32
) (
  input logic              clk,
  input logic              rst,
  nibble_reg_loader_if.slave bus
);
  localparam int CW = clog2_min1(CHANNELS);

  state_t                         state_q, state_d;
  logic [CW-1:0]                  target_q;
  logic [CHANNELS-1:0][WIDTH-1:0] regs_q;
  logic [CHANNELS-1:0]            loaded_q;
  logic                           err_q;
  logic [WIDTH-1:0]               shreg;
  logic                           last;
  logic                           start_ok;
  logic                           shift_en;
  logic                           clr_ok;
  logic                           err_set;
  logic [(1<<CW)-1:0]             ch_valid;

  // Channel-select codes that name a real channel; others are rejected
  for (genvar i = 0; i < (1 << CW); i++) begin : g_ch_valid
    assign ch_valid[i] = (i < CHANNELS);
  end

  assign start_ok = bus.start && ch_valid[bus.ch_sel];
  assign clr_ok   = bus.clr && ch_valid[bus.ch_sel];
  assign err_set  = (bus.start && !ch_valid[bus.ch_sel]) ||
                    (bus.din_valid && state_q != LOAD);

  nibble_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .clk      (clk),
    .rst      (rst),
    .restart  (start_ok),
    .shift_en (shift_en),
    .din      (bus.din),
    .shreg    (shreg),
    .last     (last)
  );

  always_comb begin
    state_d  = state_q;
    shift_en = 1'b0;
    case (state_q)
      IDLE:   if (start_ok) state_d = LOAD;
      LOAD: begin
        // Any start in LOAD drops the nibble presented with it
        if (!bus.start && bus.din_valid) begin
          shift_en = 1'b1;
          if (last) state_d = COMMIT;
        end
      end
      COMMIT: state_d = start_ok ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      target_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) target_q <= bus.ch_sel;
      if (err_set)       err_q <= 1'b1;
      else if (start_ok) err_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q   <= '0;
      loaded_q <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        // A clear to the committing channel takes priority over the commit
        if (clr_ok && bus.ch_sel == CW'(c)) begin
          regs_q[c]   <= '0;
          loaded_q[c] <= 1'b0;
        end else if (state_q == COMMIT && target_q == CW'(c)) begin
          regs_q[c]   <= shreg;
          loaded_q[c] <= 1'b1;
        end
      end
    end
  end

  assign bus.regs_out = regs_q;
  assign bus.loaded   = loaded_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.commit   = (state_q == COMMIT);
  assign bus.err      = err_q;
endmodule
